// File: rtl/prga_check.sv
// prga_check: ARC4 PRGA stage, decrypts CT into PT using S.
// Flags whether every plaintext byte is printable ASCII.
module prga_check #(
  parameter bit ABORT_EARLY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       valid,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE, HDR_RD, HDR_WR,
    SI_RD, SI_CAP, SJ_CAP,
    WR_I, WR_J, PAD_RD, PT_WR,
    DONE
  } state_t;

  state_t state, nxt;

  logic [7:0] i, j, k, len;
  logic [7:0] si, sj, c;
  logic       err;
  logic [7:0] pt_byte;
  logic       bad;
  logic       last;

  assign pt_byte = s_rddata ^ c;
  assign bad     = (pt_byte < 8'h20) || (pt_byte > 8'h7e);
  // stop after this byte: end of message or early abort
  assign last    = (k == len) || (ABORT_EARLY && (err || bad));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 8'd0;
      len   <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      c     <= 8'd0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        HDR_WR: begin
          len <= ct_rddata;
          err <= 1'b0;
          i   <= 8'd0;
          j   <= 8'd0;
          k   <= 8'd1;
          if (ct_rddata == 8'd0)
            valid <= 1'b1;
        end
        SI_RD: i <= i + 8'd1;
        SI_CAP: begin
          si <= s_rddata;
          c  <= ct_rddata;
          j  <= j + s_rddata;
        end
        SJ_CAP: sj <= s_rddata;
        PT_WR: begin
          if (bad)
            err <= 1'b1;
          if (last)
            valid <= ~(err | bad);
          else
            k <= k + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = en ? HDR_RD : IDLE;
      HDR_RD:  nxt = HDR_WR;
      HDR_WR:  nxt = (ct_rddata == 8'd0) ? DONE : SI_RD;
      SI_RD:   nxt = SI_CAP;
      SI_CAP:  nxt = SJ_CAP;
      SJ_CAP:  nxt = WR_I;
      WR_I:    nxt = WR_J;
      WR_J:    nxt = PAD_RD;
      PAD_RD:  nxt = PT_WR;
      PT_WR:   nxt = last ? DONE : SI_RD;
      DONE:    nxt = en ? HDR_RD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy       = (state == IDLE) || (state == DONE);
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state)
      HDR_WR: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      SI_RD: begin
        s_addr  = i + 8'd1;
        ct_addr = k;
      end
      SI_CAP: s_addr = j + s_rddata;
      WR_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
      end
      // when i==j this second write wins, leaving si in place
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      PAD_RD: s_addr = si + sj;
      PT_WR: begin
        pt_addr   = k;
        pt_wrdata = pt_byte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_check.sv
// tb_prga_check: two instances (abort on / abort off) with
// behavioural RC4 model and synchronous S/CT/PT memories.
module tb_prga_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en;
  logic [1:0] rdy, valid, s_wren, pt_wren;
  logic [7:0] s_addr [2];
  logic [7:0] s_rddata [2];
  logic [7:0] s_wrdata [2];
  logic [7:0] ct_addr [2];
  logic [7:0] ct_rddata [2];
  logic [7:0] pt_addr [2];
  logic [7:0] pt_wrdata [2];

  logic [7:0] smem [2][256];
  logic [7:0] sload [2][256];
  logic [7:0] ctmem [2][256];
  logic [7:0] ptmem [2][256];
  int         ptep [2][256];
  int         epoch [2] = '{0, 0};
  int         swr_cnt [2] = '{0, 0};
  int         ptwr_cnt [2] = '{0, 0};
  bit   [1:0] ld = 2'b00;

  int ncmp = 0;
  int nbad = 0;

  logic [7:0] ms [256];
  logic [7:0] mpt [256];
  bit         mw [256];
  int         mn;
  bit         mvalid;

  always #5 clk = ~clk;

  prga_check #(.ABORT_EARLY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en[0]),
    .rdy(rdy[0]), .valid(valid[0]),
    .s_addr(s_addr[0]), .s_rddata(s_rddata[0]),
    .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]),
    .pt_wren(pt_wren[0])
  );

  prga_check #(.ABORT_EARLY(1'b0)) dut_f (
    .clk(clk), .rst(rst), .en(en[1]),
    .rdy(rdy[1]), .valid(valid[1]),
    .s_addr(s_addr[1]), .s_rddata(s_rddata[1]),
    .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]),
    .pt_wren(pt_wren[1])
  );

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ld[u]) begin
        for (int a = 0; a < 256; a++)
          smem[u][a] <= sload[u][a];
      end else if (s_wren[u]) begin
        smem[u][s_addr[u]] <= s_wrdata[u];
        swr_cnt[u] <= swr_cnt[u] + 1;
      end
      s_rddata[u]  <= smem[u][s_addr[u]];
      ct_rddata[u] <= ctmem[u][ct_addr[u]];
      if (pt_wren[u]) begin
        ptmem[u][pt_addr[u]] <= pt_wrdata[u];
        ptep[u][pt_addr[u]]  <= epoch[u];
        ptwr_cnt[u] <= ptwr_cnt[u] + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic load_s(input int u, input bit ident);
    int r;
    logic [7:0] t;
    for (int a = 0; a < 256; a++)
      sload[u][a] = 8'(a);
    if (!ident) begin
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(a, 0);
        t = sload[u][a];
        sload[u][a] = sload[u][r];
        sload[u][r] = t;
      end
    end
    ld[u] = 1'b1;
    @(negedge clk);
    ld[u] = 1'b0;
  endtask

  task automatic ct4(input int u, input logic [7:0] b0,
                     input logic [7:0] b1, input logic [7:0] b2,
                     input logic [7:0] b3);
    ctmem[u][0] = b0;
    ctmem[u][1] = b1;
    ctmem[u][2] = b2;
    ctmem[u][3] = b3;
  endtask

  task automatic model_init(input int u);
    for (int a = 0; a < 256; a++)
      ms[a] = smem[u][a];
  endtask

  // plain RC4 PRGA over the model copy of S
  task automatic model_run(input int u, input bit abort);
    int ii, jj, len;
    logic [7:0] t, p;
    bit err;
    ii = 0; jj = 0; err = 1'b0; mn = 0;
    len = int'(ctmem[u][0]);
    for (int a = 0; a < 256; a++) mw[a] = 1'b0;
    mpt[0] = ctmem[u][0];
    mw[0]  = 1'b1;
    for (int k = 1; k <= len; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ms[ii])) % 256;
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
      p = ctmem[u][k] ^
          ms[(int'(ms[ii]) + int'(ms[jj])) % 256];
      mpt[k] = p;
      mw[k]  = 1'b1;
      mn = k;
      if (p < 8'h20 || p > 8'h7e) err = 1'b1;
      if (abort && err) break;
    end
    mvalid = !err;
  endtask

  // mode 0: printable, 1: any bytes, 2: one control byte
  task automatic gen_ct(input int u, input int len, input int mode);
    logic [7:0] t [256];
    logic [7:0] x, ks, p;
    int ii, jj, bp;
    for (int a = 0; a < 256; a++) t[a] = sload[u][a];
    ii = 0; jj = 0;
    bp = $urandom_range((len > 0) ? len : 1, 1);
    ctmem[u][0] = 8'(len);
    for (int k = 1; k <= len; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(t[ii])) % 256;
      x = t[ii]; t[ii] = t[jj]; t[jj] = x;
      ks = t[(int'(t[ii]) + int'(t[jj])) % 256];
      if (mode == 1) p = 8'($urandom);
      else if (mode == 2 && k == bp) p = 8'($urandom_range(31, 0));
      else p = 8'($urandom_range(126, 32));
      ctmem[u][k] = p ^ ks;
    end
  endtask

  task automatic compare(input int u, input string tag);
    int pe, se;
    pe = 0; se = 0;
    for (int a = 0; a < 256; a++) begin
      if ((ptep[u][a] == epoch[u]) != mw[a]) pe++;
      else if (mw[a] && ptmem[u][a] !== mpt[a]) pe++;
      if (smem[u][a] !== ms[a]) se++;
    end
    chk({tag, ".pt"}, pe, 0);
    chk({tag, ".s"}, se, 0);
  endtask

  task automatic run(input int u, input bit abort,
                     input string tag, input bit mid_en);
    int busy;
    model_init(u);
    model_run(u, abort);
    epoch[u]++;
    en[u] = 1'b1;
    @(negedge clk);
    en[u] = 1'b0;
    busy = 0;
    while (rdy[u] == 1'b0 && busy < 4000) begin
      busy++;
      if (mid_en && busy == 5) en[u] = 1'b1;
      if (mid_en && busy == 6) en[u] = 1'b0;
      @(negedge clk);
    end
    chk({tag, ".busy"}, busy, 2 + 7 * mn);
    chk({tag, ".valid"}, 32'(valid[u]), 32'(mvalid));
    compare(u, tag);
  endtask

  initial begin
    int busy, sw0, pw0, sw1, pw1;
    bit va;
    rst = 1'b1;
    en  = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sw0 = swr_cnt[0]; pw0 = ptwr_cnt[0];
    sw1 = swr_cnt[1]; pw1 = ptwr_cnt[1];
    repeat (10) @(negedge clk);
    chk("idle.rdy", 32'(rdy), 32'(2'b11));
    chk("idle.valid", 32'(valid), 32'(2'b00));
    chk("idle.swr", swr_cnt[0] + swr_cnt[1], sw0 + sw1);
    chk("idle.ptwr", ptwr_cnt[0] + ptwr_cnt[1], pw0 + pw1);

    for (int u = 0; u < 2; u++) begin
      load_s(u, 1'b1);
      ct4(u, 8'h03, 8'h43, 8'h47, 8'h44);
      run(u, u == 0, $sformatf("ident%0d", u), 1'b0);
      chk("ident.pt0", ptmem[u][0], 8'h03);
      chk("ident.pt1", ptmem[u][1], 8'h41);
      chk("ident.pt2", ptmem[u][2], 8'h42);
      chk("ident.pt3", ptmem[u][3], 8'h43);
      chk("ident.s2", smem[u][2], 8'h03);
      chk("ident.s3", smem[u][3], 8'h05);
      chk("ident.s5", smem[u][5], 8'h02);
      chk("ident.v", 32'(valid[u]), 1);
    end

    load_s(0, 1'b1);
    ct4(0, 8'h03, 8'h43, 8'h05, 8'h44);
    run(0, 1'b1, "abort", 1'b0);
    chk("abort.pt2", ptmem[0][2], 8'h00);
    chk("abort.pt3wr", 32'(ptep[0][3] == epoch[0]), 0);
    chk("abort.v", 32'(valid[0]), 0);
    load_s(1, 1'b1);
    ct4(1, 8'h03, 8'h43, 8'h05, 8'h44);
    run(1, 1'b0, "full", 1'b0);
    chk("full.pt3", ptmem[1][3], 8'h43);
    chk("full.v", 32'(valid[1]), 0);

    sw0 = swr_cnt[0];
    ct4(0, 8'h00, 8'h11, 8'h22, 8'h33);
    run(0, 1'b1, "empty", 1'b0);
    chk("empty.swr", swr_cnt[0], sw0);
    chk("empty.pt0", ptmem[0][0], 8'h00);
    chk("empty.v", 32'(valid[0]), 1);

    load_s(0, 1'b1);
    ct4(0, 8'h03, 8'h43, 8'h47, 8'h44);
    epoch[0]++;
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    busy = 1;
    while (busy < 9) begin
      @(negedge clk);
      busy++;
    end
    chk("mrst.busy", 32'(rdy[0]), 0);
    rst = 1'b1;
    #1;
    chk("mrst.rdy", 32'(rdy[0]), 1);
    chk("mrst.valid", 32'(valid[0]), 0);
    chk("mrst.wren", 32'({s_wren[0], pt_wren[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, 1'b1, "rerun", 1'b0);

    load_s(1, 1'b0);
    gen_ct(1, 6, 0);
    run(1, 1'b0, "miden", 1'b1);

    load_s(0, 1'b0);
    gen_ct(0, 5, 0);
    model_init(0);
    model_run(0, 1'b1);
    va = mvalid;
    epoch[0]++;
    en[0] = 1'b1;
    @(negedge clk);
    busy = 0;
    while (rdy[0] == 1'b0 && busy < 4000) begin
      busy++;
      @(negedge clk);
    end
    chk("hold.busy1", busy, 2 + 7 * mn);
    chk("hold.v1", 32'(valid[0]), 32'(va));
    epoch[0]++;
    @(negedge clk);
    chk("hold.restart", 32'(rdy[0]), 0);
    en[0] = 1'b0;
    model_run(0, 1'b1);
    busy = 1;
    @(negedge clk);
    while (rdy[0] == 1'b0 && busy < 4000) begin
      busy++;
      @(negedge clk);
    end
    chk("hold.busy2", busy, 2 + 7 * mn);
    chk("hold.v2", 32'(valid[0]), 32'(mvalid));
    compare(0, "hold2");

    for (int it = 0; it < 8; it++) begin
      int u, len, mode;
      u = it % 2;
      len = $urandom_range(40, 0);
      mode = $urandom_range(2, 0);
      load_s(u, 1'b0);
      gen_ct(u, len, mode);
      run(u, u == 0, $sformatf("rnd%0d", it), it == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
